pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-flow controller for the 9-bit single-cycle processor. Owns the program counter and the start/done handshake with the test harness.
- Converts decoder outputs (branch, how_high, load, halt) into next-PC selection, a one-cycle load wait state, and a commit enable.
- The commit enable gates register-file and data-memory writes.
- Holds a 4-entry branch-target LUT, indexed by how_high and writable from the harness.

Parameters:
- PCW, 10, program counter width in bits (instruction memory depth 2^PCW)
- CNTW, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  harness request to run program from address 0
- branch  in  1  decoder branch-taken (already qualified by zero flag)
- how_high  in  2  branch LUT index
- mem_read  in  1  current instruction is a load
- halt  in  1  current instruction is the halt/done opcode
- lut_we  in  1  LUT write enable
- lut_addr  in  2  LUT write index
- lut_data  in  PCW  LUT write data (absolute target)
- pc  out  PCW  current instruction address
- instr_valid  out  1  commit enable for RegWrite/MemWrite this cycle
- busy  out  1  program running (RUN or WAIT)
- done  out  1  program finished; level, held until next start
- instr_count  out  CNTW  retired instructions since last start

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; pc=0; instr_count=0; done=0; busy=0; instr_valid=0.
  - All LUT entries cleared to 0.
- States: IDLE, RUN, WAIT, DONE. Outputs are decoded from registered state (Moore), except instr_valid in RUN.
- IDLE:
  - start=1 -> next state RUN; pc<=0; instr_count<=0.
  - Otherwise hold.
- RUN (busy=1). Per-cycle priority: halt > mem_read > branch > sequential.
  - halt: instr_valid=1; instr_count++; pc holds; next state DONE.
  - mem_read: instr_valid=0 (write suppressed); pc holds; next state WAIT.
  - branch: instr_valid=1; pc<=LUT[how_high]; instr_count++.
  - Otherwise: instr_valid=1; pc<=pc+1, wrapping at 2^PCW-1 -> 0; instr_count++.
- WAIT (busy=1):
  - instr_valid=1; load writeback commits; pc<=pc+1; instr_count++; next state RUN.
  - Decoder inputs are ignored except the address already held.
  - Load latency: 2 cycles; all other instructions: 1 cycle.
- DONE:
  - done=1; busy=0; instr_valid=0; pc and instr_count hold.
  - start=1 -> RUN; pc<=0; instr_count<=0; done deasserts next cycle.
- start while in RUN or WAIT is ignored.
- instr_count saturates at all-ones and never wraps.
- LUT:
  - Writable in any state; the write lands at the clock edge.
  - A branch reading the same entry in the same cycle uses the old value.
  - Read is combinational.
- instr_valid is 0 in IDLE, DONE and reset regardless of inputs.
- reset_n asserted mid-program (RUN/WAIT) immediately returns all state and outputs to reset values. LUT contents are lost.

Decomposition:
- Package proc_pkg:
  - typedef enum logic [1:0] seq_state_t {IDLE, RUN, WAIT, DONE}
  - localparam PCW default
  - localparam LUT_DEPTH = 4
- Sub-module branch_lut: 4 x PCW registers with one synchronous write port, one combinational read port, and async active-low clear.
- Top: FSM, PC register, counter.

Test Plan:
- Reset/start:
  - Hold reset_n=0 with random inputs -> pc=0, busy=0, done=0, instr_valid=0.
  - Release, pulse start -> next cycle busy=1, pc=0.
- Sequential and wrap:
  - PCW=4, no branch/load/halt for 18 cycles after start -> pc counts 0..15, wraps to 0, reaches 1.
  - instr_count=18.
- Branch via LUT:
  - Write LUT[2]=0x1A3 while idle; start; at pc=5 drive branch=1, how_high=2 -> next pc=0x1A3; instr_count increments by 1.
  - Same cycle: write LUT[2]=0x050 with branch on entry 2 -> pc=0x1A3 (old value); the next branch on entry 2 -> 0x050.
- Load stall:
  - mem_read=1 at pc=7 -> cycle 1: instr_valid=0, pc=7, state WAIT; cycle 2: instr_valid=1, then pc=8.
  - Counter increments once for the load.
- Halt and restart:
  - halt=1 with mem_read=1 and branch=1 at pc=12 -> halt wins: pc stays 12, done=1, busy=0, count includes halt.
  - start in DONE -> pc=0, count=0, done=0 next cycle.
- Mid-run reset and counter saturation:
  - Assert reset_n=0 in WAIT -> outputs clear asynchronously, LUT reads 0.
  - With CNTW=4, run 20 sequential instructions -> instr_count stops at 15.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and defaults for the 9-bit processor program-flow logic.
package proc_pkg;
  localparam int PCW_DEFAULT  = 10;
  localparam int CNTW_DEFAULT = 16;
  localparam int LUT_DEPTH    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Decoder outputs consumed by the sequencer in one bundle.
  typedef struct packed {
    logic       branch;
    logic [1:0] how_high;
    logic       mem_read;
    logic       halt;
  } dec_t;
endpackage

// File: rtl/branch_lut.sv
// Branch-target table: one synchronous write port, one combinational read port.
module branch_lut
  import proc_pkg::*;
#(
  parameter int PCW = PCW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           we,
  input  logic [1:0]     waddr,
  input  logic [PCW-1:0] wdata,
  input  logic [1:0]     raddr,
  output logic [PCW-1:0] rdata
);
  logic [LUT_DEPTH-1:0][PCW-1:0] ent;

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_ent
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    ent[g] <= '0;
      else if (we && waddr == 2'(g))   ent[g] <= wdata;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata = ent[raddr];
endmodule

// File: rtl/pc_sequencer.sv
// Program-flow controller: PC, run/wait/done FSM, commit enable, retire counter.
module pc_sequencer
  import proc_pkg::*;
#(
  parameter int PCW  = PCW_DEFAULT,
  parameter int CNTW = CNTW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            branch,
  input  logic [1:0]      how_high,
  input  logic            mem_read,
  input  logic            halt,
  input  logic            lut_we,
  input  logic [1:0]      lut_addr,
  input  logic [PCW-1:0]  lut_data,
  output logic [PCW-1:0]  pc,
  output logic            instr_valid,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] instr_count
);
  seq_state_t     state, state_nxt;
  dec_t           dec;
  logic [PCW-1:0] pc_nxt, lut_rd;
  logic           commit, restart;

  assign dec = '{branch: branch, how_high: how_high, mem_read: mem_read, halt: halt};

  branch_lut #(.PCW(PCW)) u_lut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (lut_we),
    .waddr   (lut_addr),
    .wdata   (lut_data),
    .raddr   (dec.how_high),
    .rdata   (lut_rd)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    commit    = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = RUN;
        pc_nxt    = '0;
        restart   = 1'b1;
      end
      RUN: begin
        if (dec.halt) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end else if (dec.mem_read) begin
          state_nxt = WAIT;
        end else if (dec.branch) begin
          pc_nxt = lut_rd;
          commit = 1'b1;
        end else begin
          pc_nxt = pc + PCW'(1);
          commit = 1'b1;
        end
      end
      // Second cycle of a load: writeback lands, decoder inputs are ignored.
      WAIT: begin
        state_nxt = RUN;
        pc_nxt    = pc + PCW'(1);
        commit    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (restart)                            instr_count <= '0;
      else if (commit && instr_count != '1)   instr_count <= instr_count + CNTW'(1);
    end
  end

  // commit is only ever raised in RUN/WAIT, so it doubles as the write enable.
  assign instr_valid = commit;
  assign busy        = (state == RUN) || (state == WAIT);
  assign done        = (state == DONE);
endmodule
